// File: rtl/kyber_pkg.sv
// Shared Kyber constants, twiddle ROM address map and sequencer mode encodings.
package kyber_pkg;

    localparam int unsigned KYBER_Q = 3329;
    localparam int unsigned KYBER_N = 256;

    localparam logic [8:0] TW_W_BASE    = 9'd0;
    localparam logic [8:0] TW_WINV_BASE = 9'd127;
    localparam logic [8:0] TW_WMUL_BASE = 9'd254;

    localparam int unsigned TW_TOK_W = 16;

    typedef enum logic [1:0] {
        MODE_NTT  = 2'd0,
        MODE_INTT = 2'd1,
        MODE_MULT = 2'd2,
        MODE_RSVD = 2'd3
    } tw_mode_e;

    typedef struct packed {
        logic        last;
        logic [2:0]  layer;
        logic [11:0] data;
    } tw_tok_t;

    // Index of the final entry within layer l.
    function automatic logic [6:0] tw_ent_last(tw_mode_e m, logic [2:0] l);
        logic [6:0] r;
        case (m)
            MODE_NTT:  r = 7'h7f >> (3'd7 - l);
            MODE_INTT: r = 7'h7f >> ({1'b0, l} + 4'd1);
            default:   r = 7'd127;
        endcase
        return r;
    endfunction

    // Repeat count limit (repeats - 1) for each entry of layer l.
    function automatic logic [6:0] tw_rep_last(tw_mode_e m, logic [2:0] l);
        logic [6:0] r;
        case (m)
            MODE_NTT:  r = 7'h7f >> l;
            MODE_INTT: r = 7'h7f >> (3'd6 - l);
            default:   r = 7'd0;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] tw_layer_last(tw_mode_e m);
        return (m == MODE_MULT) ? 3'd0 : 3'd6;
    endfunction

endpackage

// File: rtl/tw_fifo2.sv
// Two-entry {last, layer, data} token buffer between the ROM read pipe and the PE stream.
module tw_fifo2
    import kyber_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                push_i,
    input  logic [TW_TOK_W-1:0] wdata_i,
    input  logic                pop_i,
    output logic [TW_TOK_W-1:0] rdata_o,
    output logic [1:0]          count_o,
    output logic                empty_o
);

    logic [TW_TOK_W-1:0] mem_q [2];
    logic                wr_ptr_q;
    logic                rd_ptr_q;
    logic [1:0]          cnt_q;
    logic                push_ok;
    logic                pop_ok;

    always_comb begin
        push_ok = push_i && (cnt_q != 2'd2);
        pop_ok  = pop_i && (cnt_q != 2'd0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= !wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= !rd_ptr_q;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = cnt_q;
    assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/tw_fetch.sv
// Twiddle fetch sequencer: walks the NTT/INTT/MULT twiddle order, reads the BROM and streams
// one twiddle per butterfly. Optional counters stall_cnt_o/pass_cyc_o via TW_FETCH_STATS_EN.
module tw_fetch
    import kyber_pkg::*;
#(
    parameter logic [8:0]  W_BASE    = TW_W_BASE,
    parameter logic [8:0]  WINV_BASE = TW_WINV_BASE,
    parameter logic [8:0]  WMUL_BASE = TW_WMUL_BASE,
    parameter int unsigned FIFO_D    = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [1:0]  mode_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [8:0]  rom_raddr_o,
    input  logic [11:0] rom_dout_i,
    output logic [11:0] tw_data_o,
    output logic [2:0]  tw_layer_o,
    output logic        tw_last_o,
    output logic        tw_valid_o,
    input  logic        tw_ready_i
`ifdef TW_FETCH_STATS_EN
    ,
    output logic [15:0] stall_cnt_o,
    output logic [15:0] pass_cyc_o
`endif
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e      state_q;
    tw_mode_e    mode_q;
    logic        busy_q;
    logic        done_q;
    logic [6:0]  ent_q;
    logic [6:0]  rep_q;
    logic [6:0]  base_q;
    logic [2:0]  layer_q;
    logic        gen_done_q;
    logic [8:0]  raddr_q;
    logic [11:0] held_q;

    // Two-stage read pipe: s1 = address on the ROM, s2 = ROM data valid, push into FIFO.
    logic        s1_vld_q, s1_fetch_q, s1_last_q;
    logic [2:0]  s1_layer_q;
    logic        s2_vld_q, s2_fetch_q, s2_last_q;
    logic [2:0]  s2_layer_q;

    logic [6:0]          ent_last;
    logic [6:0]          rep_last;
    logic [2:0]          layer_last;
    logic [8:0]          mode_base;
    logic [8:0]          tok_addr;
    logic [2:0]          pending;
    logic                credit_ok;
    logic                issue;
    logic                start_ok;
    logic                pop;
    logic                pass_end;
    logic [1:0]          fifo_cnt;
    logic                fifo_empty;
    logic [TW_TOK_W-1:0] fifo_wdata;
    logic [TW_TOK_W-1:0] fifo_rdata;
    tw_tok_t             head;

    always_comb begin
        ent_last   = tw_ent_last(mode_q, layer_q);
        rep_last   = tw_rep_last(mode_q, layer_q);
        layer_last = tw_layer_last(mode_q);
        case (mode_q)
            MODE_NTT:  mode_base = W_BASE;
            MODE_INTT: mode_base = WINV_BASE;
            default:   mode_base = WMUL_BASE;
        endcase
        tok_addr   = mode_base + {2'b00, base_q} + {2'b00, ent_q};
        pending    = {1'b0, fifo_cnt} + {2'b00, s1_vld_q} + {2'b00, s2_vld_q};
        credit_ok  = 32'(pending) < FIFO_D;
        issue      = (state_q == StRun) && !gen_done_q && credit_ok;
        start_ok   = start_i && (state_q == StIdle) && (mode_i != MODE_RSVD);
        pop        = !fifo_empty && tw_ready_i;
        pass_end   = (state_q == StRun) && pop && head.last && (head.layer == layer_last);
        fifo_wdata = {s2_last_q, s2_layer_q, s2_fetch_q ? rom_dout_i : held_q};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            mode_q     <= MODE_NTT;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ent_q      <= 7'd0;
            rep_q      <= 7'd0;
            base_q     <= 7'd0;
            layer_q    <= 3'd0;
            gen_done_q <= 1'b0;
            raddr_q    <= 9'd0;
            held_q     <= 12'd0;
            s1_vld_q   <= 1'b0;
            s1_fetch_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_layer_q <= 3'd0;
            s2_vld_q   <= 1'b0;
            s2_fetch_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_layer_q <= 3'd0;
        end else begin
            done_q     <= 1'b0;
            s1_vld_q   <= issue;
            s1_fetch_q <= issue && (rep_q == 7'd0);
            s1_last_q  <= (ent_q == ent_last) && (rep_q == rep_last);
            s1_layer_q <= layer_q;
            s2_vld_q   <= s1_vld_q;
            s2_fetch_q <= s1_fetch_q;
            s2_last_q  <= s1_last_q;
            s2_layer_q <= s1_layer_q;
            if (s2_vld_q && s2_fetch_q) begin
                held_q <= rom_dout_i;
            end

            case (state_q)
                StIdle: begin
                    if (start_ok) begin
                        state_q    <= StRun;
                        busy_q     <= 1'b1;
                        mode_q     <= tw_mode_e'(mode_i);
                        ent_q      <= 7'd0;
                        rep_q      <= 7'd0;
                        base_q     <= 7'd0;
                        layer_q    <= 3'd0;
                        gen_done_q <= 1'b0;
                    end
                end
                StRun: begin
                    if (issue) begin
                        // Only the first repeat of an entry touches the ROM.
                        if (rep_q == 7'd0) begin
                            raddr_q <= tok_addr;
                        end
                        if (rep_q == rep_last) begin
                            rep_q <= 7'd0;
                            if (ent_q == ent_last) begin
                                ent_q <= 7'd0;
                                if (layer_q == layer_last) begin
                                    gen_done_q <= 1'b1;
                                end else begin
                                    layer_q <= layer_q + 3'd1;
                                    base_q  <= base_q + ent_last + 7'd1;
                                end
                            end else begin
                                ent_q <= ent_q + 7'd1;
                            end
                        end else begin
                            rep_q <= rep_q + 7'd1;
                        end
                    end
                    if (pass_end) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    tw_fifo2 u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (s2_vld_q),
        .wdata_i (fifo_wdata),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_cnt),
        .empty_o (fifo_empty)
    );

    assign head        = tw_tok_t'(fifo_rdata);
    assign tw_data_o   = head.data;
    assign tw_layer_o  = head.layer;
    assign tw_last_o   = head.last;
    assign tw_valid_o  = !fifo_empty;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign rom_raddr_o = raddr_q;

`ifdef TW_FETCH_STATS_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] pass_cyc_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || start_ok) begin
            stall_cnt_q <= 16'd0;
            pass_cyc_q  <= 16'd0;
        end else begin
            if (!fifo_empty && !tw_ready_i && (stall_cnt_q != 16'hffff)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (busy_q && (pass_cyc_q != 16'hffff)) begin
                pass_cyc_q <= pass_cyc_q + 16'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign pass_cyc_o  = pass_cyc_q;
`endif

endmodule

// File: tb/tb_tw_fetch.sv
// Scoreboard bench for tw_fetch: a ROM model with the known Kyber anchor words, expected
// token streams built from the layer/entry/repeat order, and a monitor that pops and compares.
module tb_tw_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic        busy;
    logic        done;
    logic [8:0]  rom_raddr;
    logic [11:0] rom_dout;
    logic [11:0] tw_data;
    logic [2:0]  tw_layer;
    logic        tw_last;
    logic        tw_valid;
    logic        tw_ready;
`ifdef TW_FETCH_STATS_EN
    logic [15:0] stall_cnt;
    logic [15:0] pass_cyc;
`endif

    always #5 clk = ~clk;

    tw_fetch dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .mode_i      (mode),
        .busy_o      (busy),
        .done_o      (done),
        .rom_raddr_o (rom_raddr),
        .rom_dout_i  (rom_dout),
        .tw_data_o   (tw_data),
        .tw_layer_o  (tw_layer),
        .tw_last_o   (tw_last),
        .tw_valid_o  (tw_valid),
        .tw_ready_i  (tw_ready)
`ifdef TW_FETCH_STATS_EN
        ,
        .stall_cnt_o (stall_cnt),
        .pass_cyc_o  (pass_cyc)
`endif
    );

    logic [11:0] rom [0:511];
    always @(posedge clk) rom_dout <= rom[rom_raddr];

    int          total = 0;
    int          bad = 0;
    logic [16:0] exp_q [$];   // {final, last, layer, data}
    logic [15:0] got_q [$];
    int          stall_tot = 0;
    int          busy_tot = 0;
    logic        done_exp = 1'b0;
    logic        rnd_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h @%0t", name, act, req, $time);
        end
    endtask

    task automatic push_tok(input logic [8:0] a, input logic [2:0] l, input logic lst,
                            input logic fin);
        exp_q.push_back({fin, lst, l, rom[a]});
    endtask

    task automatic push_exp(input logic [1:0] m);
        int p;
        p = 0;
        if (m == 2'd0) begin
            for (int l = 0; l < 7; l++)
                for (int e = 0; e < (1 << l); e++)
                    for (int r = 0; r < (128 >> l); r++)
                        push_tok(9'((1 << l) - 1 + e), 3'(l),
                                 (e == (1 << l) - 1) && (r == (128 >> l) - 1),
                                 (l == 6) && (e == (1 << l) - 1) && (r == (128 >> l) - 1));
        end else if (m == 2'd1) begin
            for (int s = 0; s < 7; s++)
                for (int e = 0; e < (64 >> s); e++) begin
                    for (int r = 0; r < (2 << s); r++)
                        push_tok(9'(127 + p), 3'(s),
                                 (e == (64 >> s) - 1) && (r == (2 << s) - 1),
                                 (s == 6) && (e == (64 >> s) - 1) && (r == (2 << s) - 1));
                    p++;
                end
        end else begin
            for (int k = 0; k < 128; k++)
                push_tok(9'(254 + k), 3'd0, k == 127, k == 127);
        end
    endtask

    initial begin
        tw_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 tw_ready = rnd_ready ? ($urandom_range(0, 99) >= 30) : 1'b1;
        end
    end

    always @(negedge clk) begin
        logic [16:0] e;
        if (rst) begin
            done_exp = 1'b0;
        end else begin
            if (busy) busy_tot++;
            if (tw_valid && !tw_ready) stall_tot++;
            if (done || done_exp) chk("done_pulse", 32'(done), 32'(done_exp));
            done_exp = 1'b0;
            if (tw_valid && tw_ready) begin
                got_q.push_back({tw_last, tw_layer, tw_data});
                chk("fifo_bound", 32'(dut.u_fifo.count_o <= 2'd2), 32'd1);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_token: got=%0h want=none", {tw_last, tw_layer, tw_data});
                end else begin
                    e = exp_q.pop_front();
                    chk("token", 32'({tw_last, tw_layer, tw_data}), 32'(e[15:0]));
                    done_exp = e[16];
                end
            end
        end
    end

    task automatic pulse_start(input logic [1:0] m);
        @(posedge clk);
        #1 start = 1'b1;
        mode  = m;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Runs one full pass; inj drives a start pulse while busy that must be ignored.
    task automatic run_pass(input logic [1:0] m, input logic rnd, input logic inj);
        int   sb, bb;
        logic seen;
        rnd_ready = rnd;
        sb = stall_tot;
        bb = busy_tot;
        push_exp(m);
        pulse_start(m);
        @(negedge clk);
        chk("busy_after_start", 32'(busy), 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 10000 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            if (inj && c == 50) begin
                start = 1'b1;
                mode  = 2'd2;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("done_seen", 32'(seen), 32'd1);
        chk("queue_drained", exp_q.size(), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);
`ifdef TW_FETCH_STATS_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(stall_tot - sb));
        chk("pass_cyc", 32'(pass_cyc), 32'(busy_tot - bb));
`endif
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        exp_q.delete();
        rnd_ready = 1'b0;
    endtask

    initial begin
        int base;
        int c;
        for (int a = 0; a < 512; a++) rom[a] = 12'((a * 1103 + 517) % 3329);
        rom[0]   = 12'hc7c;
        rom[1]   = 12'h53a;
        rom[2]   = 12'hc04;
        rom[127] = 12'h4a6;
        rom[128] = 12'hc45;
        rom[254] = 12'h3ff;
        rom[255] = 12'h902;
        rom[256] = 12'h42c;
        rom[381] = 12'h4a6;

        rst   = 1'b1;
        start = 1'b0;
        mode  = 2'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(tw_valid), 32'd0);
        chk("rst_raddr", 32'(rom_raddr), 32'd0);
        chk("rst_data", 32'(tw_data), 32'd0);
        chk("rst_layer", 32'(tw_layer), 32'd0);
        chk("rst_last", 32'(tw_last), 32'd0);

        // NTT, ready always high
        base = got_q.size();
        run_pass(2'd0, 1'b0, 1'b0);
        chk("ntt_count", got_q.size() - base, 32'd896);
        if (got_q.size() - base >= 896) begin
            chk("ntt_tok0", 32'(got_q[base][15:0]), 32'h0c7c);
            chk("ntt_tok128", 32'(got_q[base + 128][11:0]), 32'h53a);
            chk("ntt_tok191", 32'(got_q[base + 191][11:0]), 32'h53a);
            chk("ntt_tok192", 32'(got_q[base + 192][11:0]), 32'hc04);
            chk("ntt_tok895_last", 32'(got_q[base + 895][15:12]), 32'he);
        end

        // INTT
        base = got_q.size();
        run_pass(2'd1, 1'b0, 1'b0);
        chk("intt_count", got_q.size() - base, 32'd896);
        if (got_q.size() - base >= 896) begin
            chk("intt_tok0", 32'(got_q[base][11:0]), 32'h4a6);
            chk("intt_tok1", 32'(got_q[base + 1][11:0]), 32'h4a6);
            chk("intt_tok2", 32'(got_q[base + 2][11:0]), 32'hc45);
            chk("intt_tok3", 32'(got_q[base + 3][11:0]), 32'hc45);
            chk("intt_last127", 32'(got_q[base + 127][15]), 32'd1);
            chk("intt_last255", 32'(got_q[base + 255][15]), 32'd1);
        end

        // MULT
        base = got_q.size();
        run_pass(2'd2, 1'b0, 1'b0);
        chk("mult_count", got_q.size() - base, 32'd128);
        if (got_q.size() - base >= 128) begin
            chk("mult_tok0", 32'(got_q[base][15:0]), 32'h03ff);
            chk("mult_tok1", 32'(got_q[base + 1][11:0]), 32'h902);
            chk("mult_tok2", 32'(got_q[base + 2][11:0]), 32'h42c);
            chk("mult_tok127", 32'(got_q[base + 127][15:0]), 32'h84a6);
        end

        // Random back-pressure on every mode
        run_pass(2'd0, 1'b1, 1'b0);
        run_pass(2'd1, 1'b1, 1'b0);
        run_pass(2'd2, 1'b1, 1'b0);

        // Reset in the middle of an NTT pass
        base = got_q.size();
        push_exp(2'd0);
        pulse_start(2'd0);
        c = 0;
        while (got_q.size() - base < 300 && c < 5000) begin
            @(negedge clk);
            c++;
        end
        chk("reach_tok300", 32'(got_q.size() - base >= 300), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(tw_valid), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        base = got_q.size();
        run_pass(2'd0, 1'b0, 1'b0);
        chk("post_rst_count", got_q.size() - base, 32'd896);

        // Start while busy, then a reserved-mode start
        run_pass(2'd2, 1'b1, 1'b1);
        pulse_start(2'd3);
        repeat (20) @(negedge clk);
        chk("rsvd_busy", 32'(busy), 32'd0);
        chk("rsvd_valid", 32'(tw_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
